// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, register and counter constants.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    RUN = 2'b00,
    MUL = 2'b01
  } seqState_e;

  localparam logic [REG_W-1:0]   REG_ZERO  = 5'd0;
  localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds a source of the ID instruction.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             memRead,
  input  logic [REG_W-1:0] exRt,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             usesRt,
  output logic             hit_c
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRt == idRs);
  assign rtMatch = usesRt && (exRt == idRt);

  // $zero is never a real producer, so it can never create a dependence.
  assign hit_c = memRead && (exRt != REG_ZERO) && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, EX branch flushes,
// multi-cycle multiply occupancy of EX, and a saturating stall-cycle counter.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IDEX_MemRead,
  input  logic [REG_W-1:0]   IDEX_Rt,
  input  logic [REG_W-1:0]   IFID_Rs,
  input  logic [REG_W-1:0]   IFID_Rt,
  input  logic               IFID_UsesRt,
  input  logic               IDEX_MulStart,
  input  logic               EX_BranchTaken,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IFID_Flush,
  output logic               IDEXWrite,
  output logic               IDEX_Bubble,
  output logic               EXMEM_Bubble,
  output logic               MulBusy,
  output logic [STALL_W-1:0] StallCycles
);

  // Entry cycle plus MUL cycles counting cnt down to zero gives MUL_LAT-1 stalls.
  localparam logic [CNT_W-1:0] CNT_INIT  = (MUL_LAT > 2) ? CNT_W'(MUL_LAT - 3) : '0;
  localparam bit               SHORT_MUL = (MUL_LAT == 2);

  seqState_e        state;
  seqState_e        nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;
  logic             mulDone;
  logic             nextMulDone;
  logic             loadUseHit;

  load_use_detect uLoadUse (
    .memRead (IDEX_MemRead),
    .exRt    (IDEX_Rt),
    .idRs    (IFID_Rs),
    .idRt    (IFID_Rt),
    .usesRt  (IFID_UsesRt),
    .hit_c   (loadUseHit)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      mulDone <= 1'b0;
    end else begin
      state   <= nextState;
      cnt     <= nextCnt;
      mulDone <= nextMulDone;
    end
  end

  // Next-state and control decode; mulDone lives for exactly one cycle
  always_comb begin
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXWrite    = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    MulBusy      = 1'b0;
    nextState    = state;
    nextCnt      = cnt;
    nextMulDone  = 1'b0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          if (EX_BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if (IDEX_MulStart && !mulDone) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEM_Bubble = 1'b1;
            MulBusy      = 1'b1;
            if (SHORT_MUL) begin
              nextMulDone = 1'b1;
            end else begin
              nextState = MUL;
              nextCnt   = CNT_INIT;
            end
          end else if (loadUseHit) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        MUL: begin
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXWrite    = 1'b0;
          EXMEM_Bubble = 1'b1;
          MulBusy      = 1'b1;
          if (cnt == '0) begin
            nextState   = RUN;
            nextMulDone = 1'b1;
          end else begin
            nextCnt = cnt - CNT_W'(1);
          end
        end
        default: begin
          nextState = RUN;
          nextCnt   = '0;
        end
      endcase
    end
  end

  // Performance counter of frozen-PC cycles, sticky at full scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
    end else if (!PCWrite && (StallCycles != STALL_MAX)) begin
      StallCycles <= StallCycles + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Random and directed check of hazard_sequencer at MUL_LAT 4, 2 and 255 against a cycle-level reference model.
module tb_hazard_sequencer;

  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{4, 2, 255};

  // Control vector order: PCWrite IFIDWrite IFID_Flush IDEXWrite IDEX_Bubble EXMEM_Bubble MulBusy
  localparam logic [6:0] V_IDLE  = 7'b1101000;
  localparam logic [6:0] V_MUL   = 7'b0000011;
  localparam logic [6:0] V_FLUSH = 7'b1111100;
  localparam logic [6:0] V_LU    = 7'b0001100;

  logic       clk = 1'b0;
  logic       rst;
  logic       memRead;
  logic [4:0] exRt;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       usesRt;
  logic       mulStart;
  logic       brTaken;

  logic        pcw   [NDUT];
  logic        ifidw [NDUT];
  logic        flush [NDUT];
  logic        idexw [NDUT];
  logic        bub   [NDUT];
  logic        exbub [NDUT];
  logic        busy  [NDUT];
  logic [15:0] sc    [NDUT];

  int checks = 0;
  int errors = 0;

  // Reference model: stall cycles still owed by the current multiply, one-cycle re-trigger block, stall count
  int busyLeft [NDUT];
  bit blockMul [NDUT];
  int stallRef [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    hazard_sequencer #(.MUL_LAT(LATS[g])) uDut (
      .clk            (clk),
      .rst            (rst),
      .IDEX_MemRead   (memRead),
      .IDEX_Rt        (exRt),
      .IFID_Rs        (idRs),
      .IFID_Rt        (idRt),
      .IFID_UsesRt    (usesRt),
      .IDEX_MulStart  (mulStart),
      .EX_BranchTaken (brTaken),
      .PCWrite        (pcw[g]),
      .IFIDWrite      (ifidw[g]),
      .IFID_Flush     (flush[g]),
      .IDEXWrite      (idexw[g]),
      .IDEX_Bubble    (bub[g]),
      .EXMEM_Bubble   (exbub[g]),
      .MulBusy        (busy[g]),
      .StallCycles    (sc[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrlOf(input int k);
    return {pcw[k], ifidw[k], flush[k], idexw[k], bub[k], exbub[k], busy[k]};
  endfunction

  // One clock: compare at the falling edge, then advance the model across the rising edge
  task automatic step();
    logic [6:0] exp;
    bit lu;
    bit nblock;
    @(negedge clk);
    lu = memRead && (exRt != 5'd0) && ((exRt == idRs) || (usesRt && (exRt == idRt)));
    for (int k = 0; k < NDUT; k++) begin
      nblock = 1'b0;
      if (rst) begin
        exp = V_IDLE;
        busyLeft[k] = 0;
        stallRef[k] = 0;
      end else if (busyLeft[k] > 0) begin
        exp = V_MUL;
        busyLeft[k]--;
        nblock = (busyLeft[k] == 0);
      end else if (brTaken) begin
        exp = V_FLUSH;
      end else if (mulStart && !blockMul[k]) begin
        exp = V_MUL;
        busyLeft[k] = LATS[k] - 2;
        nblock = (LATS[k] == 2);
      end else if (lu) begin
        exp = V_LU;
      end else begin
        exp = V_IDLE;
      end
      check($sformatf("d%0d_ctrl", k), 32'(ctrlOf(k)), 32'(exp));
      check($sformatf("d%0d_stall", k), 32'(sc[k]), 32'(stallRef[k]));
      if (!rst && !exp[6] && stallRef[k] < 65535) stallRef[k]++;
      blockMul[k] = nblock;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; memRead = 1'b0; exRt = '0; idRs = '0; idRt = '0;
    usesRt = 1'b0; mulStart = 1'b0; brTaken = 1'b0;
  endtask

  task automatic doReset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      busyLeft[k] = 0; blockMul[k] = 1'b0; stallRef[k] = 0;
    end
    doReset();
    check("reset_stall", 32'(sc[0]), 32'd0);
    check("reset_pcw", 32'(pcw[0]), 32'd1);

    // Load-use on rs: single stall then idle
    memRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
    step();
    quiet();
    check("lu_count", 32'(sc[0]), 32'd1);
    step();

    // $zero and unused-rt cases do not stall
    memRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
    step();
    exRt = 5'd5; idRs = 5'd1; idRt = 5'd5; usesRt = 1'b0;
    step();
    usesRt = 1'b1;
    step();
    quiet();
    check("no_stall_cases", 32'(sc[0]), 32'd2);

    // Multiply held 4 cycles
    doReset();
    mulStart = 1'b1;
    repeat (4) step();
    quiet();
    check("mul4_stalls", 32'(sc[0]), 32'd3);
    check("mul2_stalls", 32'(sc[1]), 32'd2);
    step();

    // Reset on the second stall cycle abandons the multiply
    doReset();
    mulStart = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    check("rst_mid_mul", 32'(ctrlOf(0)), 32'(V_IDLE));
    rst = 1'b0;
    mulStart = 1'b0;
    step();

    // Branch outranks multiply and load-use
    brTaken = 1'b1; mulStart = 1'b1; memRead = 1'b1; exRt = 5'd7; idRs = 5'd7;
    step();
    quiet();
    step();

    // Random traffic, small register set so matches are frequent
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(63) == 0);
      memRead  = 1'($urandom_range(1));
      exRt     = 5'($urandom_range(3));
      idRs     = 5'($urandom_range(3));
      idRt     = 5'($urandom_range(3));
      usesRt   = 1'($urandom_range(1));
      mulStart = ($urandom_range(3) == 0);
      brTaken  = ($urandom_range(7) == 0);
      step();
    end

    // Long MUL_LAT=255 stream drives the counter into saturation
    doReset();
    mulStart = 1'b1;
    repeat (66100) step();
    check("sat_hold", 32'(sc[2]), 32'h0000FFFF);
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
